// File: rtl/router_pkg.sv
// Shared types for the router input side: FSM state encoding and a width helper
// used by the FSM, the synchroniser and the register blocks.
package router_pkg;

  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    StDecode = 4'd0,
    StLfd    = 4'd1,
    StWait   = 4'd2,
    StLd     = 4'd3,
    StLp     = 4'd4,
    StChk    = 4'd5,
    StFull   = 4'd6,
    StLaf    = 4'd7,
    StDrop   = 4'd8
  } state_e;

  // $clog2 that never returns zero, so a degenerate range still yields a 1-bit field.
  function automatic int unsigned clog2_min1(input int unsigned value);
    return (value < 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/router_wait_timer.sv
// Saturating WAIT-state cycle counter; flags expiry one count before WAIT_TIMEOUT
// so the FSM leaves WAIT after exactly WAIT_TIMEOUT cycles.
module router_wait_timer
  import router_pkg::*;
#(
  parameter int unsigned WAIT_TIMEOUT = 32
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int unsigned CNT_W = clog2_min1(WAIT_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WAIT_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = (WAIT_TIMEOUT == 0) ? '0 : CNT_W'(WAIT_TIMEOUT - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != CNT_MAX)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (WAIT_TIMEOUT != 0) && (r_count == CNT_LAST);

endmodule

// File: rtl/router_fsm_param.sv
// Input-side router control FSM: header decode, load sequencing, full stall,
// per-destination soft reset and drop handling for bad addresses and wait timeouts.
module router_fsm_param
  import router_pkg::*;
#(
  parameter int unsigned NUM_PORTS    = 3,
  parameter int unsigned ADDR_W       = $clog2(NUM_PORTS),
  parameter int unsigned WAIT_TIMEOUT = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_pkt_valid,
  input  logic [ADDR_W-1:0]    i_data_in,
  input  logic                 i_fifo_full,
  input  logic [NUM_PORTS-1:0] i_fifo_empty,
  input  logic [NUM_PORTS-1:0] i_sft_rst,
  input  logic                 i_parity_done,
  input  logic                 i_low_pkt_valid,
  output logic [NUM_PORTS-1:0] o_dest_sel,
  output logic                 o_busy,
  output logic                 o_detect_add,
  output logic                 o_lfd_state,
  output logic                 o_ld_state,
  output logic                 o_laf_state,
  output logic                 o_full_state,
  output logic                 o_write_enb_reg,
  output logic                 o_rst_int_reg,
  output logic                 o_drop_state,
  output logic                 o_addr_err,
  output logic                 o_timeout_err
);

  state_e               r_state, w_state_nxt;
  logic [NUM_PORTS-1:0] r_dest_sel, w_dest_sel_nxt;
  logic                 r_addr_err, w_addr_err_nxt;
  logic                 r_timeout_err, w_timeout_err_nxt;
  logic [NUM_PORTS-1:0] w_hdr_onehot;
  logic                 w_hdr_illegal;
  logic                 w_wait_expired;
  logic                 w_sft_hit;

  // Shifting past the top bit yields zero, which only happens for illegal addresses.
  assign w_hdr_onehot  = {{(NUM_PORTS-1){1'b0}}, 1'b1} << i_data_in;
  assign w_hdr_illegal = 32'(i_data_in) >= NUM_PORTS;
  assign w_sft_hit     = (r_state != StDecode) && |(i_sft_rst & r_dest_sel);

  router_wait_timer #(
    .WAIT_TIMEOUT (WAIT_TIMEOUT)
  ) u_wait_timer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clr     (r_state != StWait),
    .i_en      (r_state == StWait),
    .o_expired (w_wait_expired)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state       <= StDecode;
      r_dest_sel    <= '0;
      r_addr_err    <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_dest_sel    <= w_dest_sel_nxt;
      r_addr_err    <= w_addr_err_nxt;
      r_timeout_err <= w_timeout_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_dest_sel_nxt    = r_dest_sel;
    w_addr_err_nxt    = 1'b0;
    w_timeout_err_nxt = 1'b0;
    unique case (r_state)
      StDecode: begin
        if (i_pkt_valid) begin
          if (w_hdr_illegal) begin
            w_state_nxt    = StDrop;
            w_addr_err_nxt = 1'b1;
          end else begin
            w_dest_sel_nxt = w_hdr_onehot;
            w_state_nxt    = |(i_fifo_empty & w_hdr_onehot) ? StLfd : StWait;
          end
        end
      end
      StLfd:  w_state_nxt = StLd;
      StWait: begin
        // Empty on the expiry edge still wins: no drop, no error.
        if (|(i_fifo_empty & r_dest_sel)) begin
          w_state_nxt = StLfd;
        end else if (w_wait_expired) begin
          w_state_nxt       = StDrop;
          w_timeout_err_nxt = 1'b1;
        end
      end
      StLd: begin
        if (i_fifo_full)       w_state_nxt = StFull;
        else if (!i_pkt_valid) w_state_nxt = StLp;
      end
      StLp:   w_state_nxt = StChk;
      StChk:  w_state_nxt = i_fifo_full ? StFull : StDecode;
      StFull: if (!i_fifo_full) w_state_nxt = StLaf;
      StLaf: begin
        if (i_parity_done)        w_state_nxt = StDecode;
        else if (i_low_pkt_valid) w_state_nxt = StLp;
        else                      w_state_nxt = StLd;
      end
      StDrop: if (!i_pkt_valid) w_state_nxt = StDecode;
      default: w_state_nxt = StDecode;
    endcase

    if (w_sft_hit) begin
      w_state_nxt       = StDecode;
      w_timeout_err_nxt = 1'b0;
    end
    if (w_state_nxt == StDecode) begin
      w_dest_sel_nxt = '0;
    end
  end

  always_comb begin
    o_busy          = (r_state == StLfd) || (r_state == StWait) || (r_state == StLp) ||
                      (r_state == StChk) || (r_state == StFull) || (r_state == StLaf);
    o_detect_add    = (r_state == StDecode);
    o_lfd_state     = (r_state == StLfd);
    o_ld_state      = (r_state == StLd);
    o_laf_state     = (r_state == StLaf);
    o_full_state    = (r_state == StFull);
    o_write_enb_reg = (r_state == StLd) || (r_state == StLp) || (r_state == StLaf);
    o_rst_int_reg   = (r_state == StChk);
    o_drop_state    = (r_state == StDrop);
    o_dest_sel      = r_dest_sel;
    o_addr_err      = r_addr_err;
    o_timeout_err   = r_timeout_err;
  end

endmodule
